// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared types, funct3 encodings and fault rule for the load/store unit
package mau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int CNT_W = 8;

  // Illegal encoding, misalignment, or simultaneous read and write.
  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] lo);
    logic illegal;
    if (rd && wr)
      illegal = 1'b1;
    else if (wr)
      illegal = !(f3 == SB || f3 == SH || f3 == SW);
    else
      illegal = !(f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
    return illegal || (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/acknowledge port
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mau_align.sv
// rtl/mau_align.sv - store lane replication/strobes and load extraction/extension
module mau_align
  import mau_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = st_data;
    if (st_we) begin
      case (st_funct3)
        SB: begin
          wstrb = 4'b0001 << st_off;
          wdata = {4{st_data[7:0]}};
        end
        SH: begin
          wstrb = st_off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{st_data[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data = {24'd0, ld_byte};
      LHU:     ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with stall, fault and bus timeout
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               adv,
  output logic               stall,
  output logic [31:0]        load_data,
  output logic               fault,
  output logic               bus_err,
  mem_access_unit_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [3:0]       wstrb_q;
  logic             req_q;
  logic             memop;
  logic             accept;
  logic             timeout;
  logic [3:0]       st_wstrb;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_fmt;

  assign memop   = in_valid & (mem_read | mem_write);
  assign fault   = memop & access_fault(mem_read, mem_write, funct3, addr[1:0]);
  assign timeout = (cnt == CNT_LAST);

  mau_align u_align (
    .st_we     (mem_write),
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .wstrb     (st_wstrb),
    .wdata     (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_off    (addr_q[1:0]),
    .rdata     (bus.mem_rdata),
    .ld_data   (ld_fmt)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memop && !fault) begin
          accept    = 1'b1;
          stall     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // The op still on the inputs is the one just serviced; only adv moves on.
        if (adv) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
      req_q     <= 1'b0;
      load_data <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == ST_WAIT);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            we_q     <= mem_write;
            wstrb_q  <= st_wstrb;
            wdata_q  <= st_wdata;
          end else if (fault) begin
            load_data <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            load_data <= we_q ? 32'd0 : ld_fmt;
          end else if (timeout) begin
            load_data <= '0;
            bus_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (adv) begin
            bus_err <= 1'b0;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;

endmodule
